// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single main-memory port between icache refill and dcache refill/write-back.
// Latency: strobes rise one edge after a request is seen in IDLE; completion is passed through combinationally.
// Backpressure: requesters stall on busywait until their completion cycle; memory stalls via mem_busywait.
module memory_bus_arbiter #(
    parameter int ADDR_W         = 28,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_address,
    output logic [DATA_W-1:0] ic_readdata,
    output logic              ic_busywait,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_address,
    input  logic [DATA_W-1:0] dc_writedata,
    output logic [DATA_W-1:0] dc_readdata,
    output logic              dc_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              bus_error
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              last_grant_d;   // set when the dcache won the most recent tie
    logic [WD_W-1:0]   wd_cnt;
    logic              ic_req;
    logic              dc_req;
    logic              tie;
    logic              serving;
    logic              mem_done;
    logic              wd_expire;
    logic              xfer_done;

    assign ic_req    = ic_read;
    assign dc_req    = dc_read | dc_write;
    assign tie       = ic_req & dc_req;
    assign serving   = (state != IDLE);
    assign mem_done  = serving & ~mem_busywait;
    assign wd_expire = serving & mem_busywait & (wd_cnt == WD_LAST);
    assign xfer_done = mem_done | wd_expire;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tie)
                    state_nxt = last_grant_d ? SERVE_I : SERVE_D;
                else if (dc_req)
                    state_nxt = SERVE_D;
                else if (ic_req)
                    state_nxt = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (xfer_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_d  <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            wd_cnt        <= '0;
            bus_error     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                wd_cnt <= '0;
                if (tie)
                    last_grant_d <= (state_nxt == SERVE_D);
                if (state_nxt == SERVE_I) begin
                    mem_read    <= 1'b1;
                    mem_write   <= 1'b0;
                    mem_address <= ic_address;
                end else if (state_nxt == SERVE_D) begin
                    // read+write together is resolved as a write
                    mem_read    <= ~dc_write;
                    mem_write   <= dc_write;
                    mem_address <= dc_address;
                    if (dc_write)
                        mem_writedata <= dc_writedata;
                end
            end else if (xfer_done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_expire)
                bus_error <= 1'b1;
        end
    end

    assign ic_busywait = ic_req & ~((state == SERVE_I) & xfer_done);
    assign dc_busywait = dc_req & ~((state == SERVE_D) & xfer_done);
    assign ic_readdata = ((state == SERVE_I) & mem_done) ? mem_readdata : '0;
    assign dc_readdata = ((state == SERVE_D) & mem_done & mem_read) ? mem_readdata : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_memory_bus_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int T  = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, ic_read, dc_read, dc_write, mem_busywait;
    logic [AW-1:0] ic_address, dc_address, mem_address;
    logic [DW-1:0] dc_writedata, mem_readdata, ic_readdata, dc_readdata, mem_writedata;
    logic          ic_busywait, dc_busywait, mem_read, mem_write, bus_error;

    memory_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .ic_read(ic_read), .ic_address(ic_address), .ic_readdata(ic_readdata), .ic_busywait(ic_busywait),
        .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address), .dc_writedata(dc_writedata),
        .dc_readdata(dc_readdata), .dc_busywait(dc_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .bus_error(bus_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner 0=none, 1=icache, 2=dcache; k = 1-based serve cycle; lat = memory latency of this transfer
    int            m_owner = 0, m_k = 0, m_lat = 1, m_last_tie = 1;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_berr = 1'b0;

    int            next_lat = 1;
    logic          rand_rdata = 1'b1;
    logic [DW-1:0] fixed_rdata = '0;
    logic          exp_ic_bw = 1'b0, exp_dc_bw = 1'b0;

    logic          o_mr, o_mw, o_ibw, o_dbw, o_berr;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd, o_ird, o_drd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_check();
        bit act_  = (m_owner != 0);
        bit real_ = act_ && (m_k >= m_lat);
        bit done_ = act_ && ((m_k >= m_lat) || (m_k == T));
        exp_ic_bw = ic_read && !(m_owner == 1 && done_);
        exp_dc_bw = (dc_read || dc_write) && !(m_owner == 2 && done_);
        chk("mem_read", DW'(mem_read), DW'(act_ && !m_wr));
        chk("mem_write", DW'(mem_write), DW'(act_ && m_wr));
        if (act_) chk("mem_address", DW'(mem_address), DW'(m_addr));
        if (act_ && m_wr) chk("mem_writedata", mem_writedata, m_wdata);
        chk("ic_busywait", DW'(ic_busywait), DW'(exp_ic_bw));
        chk("dc_busywait", DW'(dc_busywait), DW'(exp_dc_bw));
        chk("ic_readdata", ic_readdata, (m_owner == 1 && real_) ? mem_readdata : '0);
        chk("dc_readdata", dc_readdata, (m_owner == 2 && real_ && !m_wr) ? mem_readdata : '0);
        chk("bus_error", DW'(bus_error), DW'(m_berr));
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner = 0; m_last_tie = 1; m_berr = 1'b0;
            return;
        end
        if (m_owner == 0) begin
            int win = 0;
            bit ir = ic_read;
            bit dr = dc_read || dc_write;
            if (ir && dr) begin
                win = (m_last_tie == 1) ? 2 : 1;
                m_last_tie = win;
            end else if (ir) win = 1;
            else if (dr) win = 2;
            if (win != 0) begin
                m_owner = win; m_k = 1; m_lat = next_lat;
                if (win == 1) begin
                    m_wr = 1'b0; m_addr = ic_address;
                end else begin
                    m_wr = dc_write; m_addr = dc_address; m_wdata = dc_writedata;
                end
            end
        end else if (m_k >= m_lat || m_k == T) begin
            if (m_k < m_lat) m_berr = 1'b1;
            m_owner = 0;
        end else begin
            m_k++;
        end
    endtask

    task automatic mem_drive();
        if (m_owner != 0) mem_busywait = (m_k < m_lat);
        else              mem_busywait = 1'($urandom_range(0, 1));
        mem_readdata = rand_rdata ? rnd128() : fixed_rdata;
    endtask

    // Inputs set by the caller are held for the current cycle; outputs are sampled at the falling edge.
    task automatic cycle();
        @(negedge clock);
        o_mr = mem_read; o_mw = mem_write; o_addr = mem_address; o_wd = mem_writedata;
        o_ibw = ic_busywait; o_dbw = dc_busywait; o_ird = ic_readdata; o_drd = dc_readdata;
        o_berr = bus_error;
        model_check();
        model_step();
        @(posedge clock);
        #1;
        mem_drive();
    endtask

    initial begin
        logic [DW-1:0] wpat;
        reset = 1'b1; ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
        ic_address = '0; dc_address = '0; dc_writedata = '0;
        mem_busywait = 1'b0; mem_readdata = '0;
        @(posedge clock);
        #1;
        mem_drive();
        cycle();
        cycle();
        chk("rst_addr", DW'(o_addr), '0);
        chk("rst_wdata", o_wd, '0);

        reset = 1'b0;
        repeat (10) cycle();
        chk("idle_strobes", DW'({o_mr, o_mw}), '0);
        chk("idle_busywait", DW'({o_ibw, o_dbw}), '0);
        chk("idle_berr", DW'(o_berr), '0);

        // single icache read, 5-cycle memory
        rand_rdata = 1'b0;
        fixed_rdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        ic_read = 1'b1; ic_address = 28'h10; next_lat = 5;
        cycle();
        chk("ic_req_cycle_bw", DW'(o_ibw), DW'(1));
        chk("ic_req_cycle_mr", DW'(o_mr), '0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ic_serve_mr", DW'(o_mr), DW'(1));
            chk("ic_serve_addr", DW'(o_addr), DW'(28'h10));
            chk("ic_serve_bw", DW'(o_ibw), (i == 4) ? '0 : DW'(1));
            if (i == 4) chk("ic_rdata", o_ird, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        end
        ic_read = 1'b0;
        cycle();
        chk("ic_back_idle", DW'(o_mr), '0);

        // first tie goes to dcache, next tie to icache
        wpat = 128'h11112222_33334444_55556666_77778888;
        ic_read = 1'b1; dc_write = 1'b1; dc_address = 28'hABC; dc_writedata = wpat; next_lat = 1;
        cycle();
        cycle();
        chk("tie1_mw", DW'(o_mw), DW'(1));
        chk("tie1_wdata", o_wd, wpat);
        chk("tie1_addr", DW'(o_addr), DW'(28'hABC));
        chk("tie1_dbw", DW'(o_dbw), '0);
        chk("tie1_ibw", DW'(o_ibw), DW'(1));
        dc_write = 1'b0;
        cycle();
        chk("tie1_dead", DW'({o_mr, o_mw}), '0);
        cycle();
        chk("tie1_i_mr", DW'(o_mr), DW'(1));
        chk("tie1_i_bw", DW'(o_ibw), '0);
        ic_read = 1'b0;
        cycle();
        ic_read = 1'b1; dc_read = 1'b1; dc_address = 28'h55;
        cycle();
        cycle();
        chk("tie2_i_first", DW'(o_addr), DW'(28'h10));
        chk("tie2_dbw", DW'(o_dbw), DW'(1));
        ic_read = 1'b0;
        cycle();
        cycle();
        chk("tie2_d_addr", DW'(o_addr), DW'(28'h55));
        chk("tie2_d_rdata", o_drd, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        dc_read = 1'b0;
        cycle();

        // dcache read arriving during an icache transfer
        rand_rdata = 1'b1;
        ic_read = 1'b1; ic_address = 28'h20; next_lat = 4;
        cycle();
        cycle();
        dc_read = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            dc_address = AW'(28'h100 + k);
            cycle();
            chk("wait_dbw", DW'(o_dbw), DW'(1));
            chk("wait_iaddr", DW'(o_addr), DW'(28'h20));
        end
        ic_read = 1'b0; dc_address = 28'h200; next_lat = 3;
        cycle();
        chk("wait_dead", DW'(o_mr), '0);
        chk("wait_dead_dbw", DW'(o_dbw), DW'(1));
        for (int i = 0; i < 3; i++) begin
            dc_address = AW'(28'h300 + i);
            cycle();
            chk("wait_d_addr", DW'(o_addr), DW'(28'h200));
        end
        chk("wait_d_done", DW'(o_dbw), '0);
        dc_read = 1'b0;
        cycle();

        // hung memory: forced completion on serve cycle 16
        ic_read = 1'b1; ic_address = 28'h40; next_lat = 1000;
        cycle();
        for (int i = 0; i < T; i++) begin
            cycle();
            chk("to_bw", DW'(o_ibw), (i == T - 1) ? '0 : DW'(1));
            chk("to_berr_pre", DW'(o_berr), '0);
            if (i == T - 1) chk("to_rdata", o_ird, '0);
        end
        ic_read = 1'b0;
        cycle();
        chk("to_berr", DW'(o_berr), DW'(1));
        chk("to_idle", DW'(o_mr), '0);
        dc_write = 1'b1; dc_writedata = rnd128(); next_lat = 2;
        repeat (3) cycle();
        dc_write = 1'b0;
        cycle();
        chk("to_berr_sticky", DW'(o_berr), DW'(1));

        // reset during a dcache transfer
        dc_read = 1'b1; dc_address = 28'h77; next_lat = 10;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_mid_mr_before", DW'(o_mr), DW'(1));
        reset = 1'b0; next_lat = 2;
        cycle();
        chk("rst_mid_mr", DW'(o_mr), '0);
        chk("rst_mid_berr", DW'(o_berr), '0);
        chk("rst_mid_dbw", DW'(o_dbw), DW'(1));
        cycle();
        chk("rst_regrant", DW'(o_mr), DW'(1));
        chk("rst_regrant_addr", DW'(o_addr), DW'(28'h77));
        cycle();
        chk("rst_regrant_done", DW'(o_dbw), '0);
        dc_read = 1'b0;
        cycle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (ic_read && !exp_ic_bw) ic_read = 1'b0;
            else if (!ic_read && $urandom_range(0, 2) == 0) begin
                ic_read = 1'b1; ic_address = AW'($urandom);
            end
            if ((dc_read || dc_write) && !exp_dc_bw) begin
                dc_read = 1'b0; dc_write = 1'b0;
            end else if (!(dc_read || dc_write) && $urandom_range(0, 2) == 0) begin
                int r = $urandom_range(0, 7);
                dc_write = (r < 3) || (r == 7);
                dc_read  = (r >= 3);
                dc_address = AW'($urandom);
                dc_writedata = rnd128();
            end else if ($urandom_range(0, 3) == 0) begin
                dc_address = AW'($urandom);
                dc_writedata = rnd128();
            end
            next_lat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 6);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path. Sits between both caches' miss handlers and main memory. Grants one block transfer at a time, returns per-requester busywait in the same style the caches already use, and flags hung memory transactions with a watchdog.

## Interface
Parameters:
- ADDR_W, 28, block address width (byte address [31:4])
- DATA_W, 128, block data width
- TIMEOUT_CYCLES, 256, max cycles a grant may stay open before abort

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- ic_read  in  1  icache block-read request, held until ic_busywait low
- ic_address  in  ADDR_W  icache block address
- ic_readdata  out  DATA_W  block returned to icache
- ic_busywait  out  1  icache stall
- dc_read, dc_write  in  1 each  dcache request (never both high)
- dc_address  in  ADDR_W  dcache block address
- dc_writedata  in  DATA_W  dcache write-back block
- dc_readdata  out  DATA_W  block returned to dcache
- dc_busywait  out  1  dcache stall
- mem_read, mem_write  out  1 each  main-memory strobes
- mem_address  out  ADDR_W
- mem_writedata  out  DATA_W
- mem_readdata  in  DATA_W
- mem_busywait  in  1  high while the strobed access is in progress; low in its completion cycle
- bus_error  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE: if only ic_read is high, go to SERVE_I; if only dc_read|dc_write is high, go to SERVE_D; if both, grant the requester not in last_grant, then update last_grant. No request: stay.
- SERVE_x: latched address, data and direction drive the mem_* outputs from registers. Input changes during service are ignored.
- Completion: state SERVE_x and mem_busywait==0. In that cycle, x_busywait is low and x_readdata = mem_readdata (combinational pass-through; zero for writes). On the next edge, go to IDLE with strobes low.
- x_busywait = x_request & ~(state==SERVE_x & completion). It is combinational, so it is high in the same cycle the request rises.
- Non-granted readdata outputs are 0.
- Watchdog: a counter clears on entry to SERVE_x and increments each SERVE cycle. When it reaches TIMEOUT_CYCLES-1 without completion, that cycle is treated as completion with readdata 0, and bus_error sets. bus_error is cleared only by reset.
- A requester dropping its request mid-service is illegal. The transfer still runs to completion and its result is discarded.
- dc_read and dc_write high together is illegal; it is treated as a write.

## Timing
- Reset values: state IDLE, last_grant=I (dcache wins the first tie), mem_read=mem_write=0, mem_address=0, mem_writedata=0, watchdog=0, bus_error=0. busywait outputs follow the combinational rule, so they are 0 with no requests.
- Reset mid-transfer: strobes are low after the reset edge and the transfer is abandoned. Requesters still holding requests see busywait high and are re-arbitrated.
- Grant latency: request seen at edge N in IDLE; strobes are high from edge N+1.
- Return to IDLE takes one cycle after completion. Back-to-back transfers therefore have one dead IDLE cycle between strobe periods.
- Minimum requester stall: request cycle + grant + memory latency. With a memory completing in its first strobed cycle, the requester sees busywait low in cycle 2 after the request rises.
- Round-robin applies only to ties sampled in IDLE. A request arriving while the other requester is being served waits at most one transfer plus one IDLE cycle.

## Test plan
- Reset then idle: no requests for 10 cycles -> all strobes 0, both busywaits 0, bus_error 0.
- Single icache read of address 0x0000010, memory with 5-cycle latency returning 0xDEADBEEF_… -> mem_read high with mem_address 0x10 from cycle 1, ic_busywait low exactly in the completion cycle, ic_readdata equals the memory data, then IDLE.
- Simultaneous ic_read and dc_write after reset -> dcache served first with the correct mem_writedata. The icache is granted in the following IDLE cycle. The next simultaneous tie grants the icache first.
- dcache read arriving while an icache transfer is in flight -> dc_busywait stays high throughout and is served after exactly one IDLE cycle. Address and data are not corrupted by the changing dc_address during the wait.
- Memory never drops mem_busywait, TIMEOUT_CYCLES=16 -> forced completion on SERVE cycle 16 with readdata 0. bus_error stays 1 through later good transfers until reset.
- Reset asserted during SERVE_D -> strobes 0 after the edge, bus_error 0, and the pending dcache request is re-granted after reset is released.
